tcdm_bank_arbiter: RTL and testbench
====================================

# tcdm_bank_arbiter

Shares one TCDM SRAM bank between `NumReq` requesters: the tile's local crossbar port and one or more remote interconnect ports. The block performs round-robin arbitration each cycle, drives the single bank port, and tracks in-flight reads through the bank's fixed read latency so each read response reaches the requester that issued it. It sits between the tile crossbar/interconnect outputs and each SRAM bank macro inside a tile.

## Interface
Parameters:
- `NumReq`, default 2: number of requesters; legal range 1..16.
- `AddrMemWidth`, default 10: bank word-address width.
- `DataWidth`, default 32: data width; must be a multiple of 8.
- `MemLatency`, default 1: SRAM read latency in cycles; legal range 1..3.

Ports:
- `clk_i` in 1: clock, the only clock.
- `rst_i` in 1: reset, synchronous and active-high.
- `req_i` in `NumReq`: per-requester request.
- `addr_i` in `NumReq`×`AddrMemWidth`: per-requester word address.
- `wen_i` in `NumReq`: 1 = write, 0 = read.
- `wdata_i` in `NumReq`×`DataWidth`: write data.
- `be_i` in `NumReq`×`DataWidth/8`: byte enables.
- `gnt_o` out `NumReq`: grant; one-hot or zero.
- `rvalid_o` out `NumReq`: read-response valid; one-hot or zero.
- `rdata_o` out `DataWidth`: read data, broadcast to all requesters and qualified by `rvalid_o`.
- `bank_req_o` out 1: bank request.
- `bank_addr_o` out `AddrMemWidth`: bank address.
- `bank_wen_o` out 1: bank write enable.
- `bank_wdata_o` out `DataWidth`: bank write data.
- `bank_be_o` out `DataWidth/8`: bank byte enables.
- `bank_rdata_i` in `DataWidth`: bank read data, valid `MemLatency` cycles after the request.

## Operation
- **Arbitration:** combinational round-robin over `req_i`.
  - The search starts at pointer `rr_q` and wraps modulo `NumReq`.
  - The first asserted requester wins and receives `gnt_o[w]=1` in the same cycle.
- **Bank drive:** when there is a winner, `bank_req_o=1` and the bank signals mux the winner's `addr`/`wen`/`wdata`/`be`.
  - With no request: `bank_req_o=0`, `bank_wen_o=0`, other bank outputs 0.
- **Pointer update:** when a grant occurs, `rr_q <= (w+1) mod NumReq` on the next edge. With no grant, `rr_q` holds.
- **Fairness:** a continuously requesting port waits at most `NumReq-1` cycles between grants.
- **Response tracking:** a `MemLatency`-deep shift register of {valid, index}.
  - Stage 0 is loaded with {1, w} for a granted read, and {0, x} otherwise.
  - Writes produce no response.
- **Response output:** `rvalid_o[idx]=1` when the last stage is valid. `rdata_o = bank_rdata_i` combinationally, with no extra register.
- **Back-to-back reads:** are accepted every cycle, and responses come back in grant order.
- **Request protocol:**
  - A requester holds `req_i` and its payload until granted.
  - Requesters may drop `req_i` without a grant; the arbiter does not check this.
- **`NumReq=1`:** `gnt_o = req_i`, the pointer is constant 0, and the index field has width 1, tied to 0.
- **Reset:**
  - `rr_q=0` and all shift-register valids are 0, so in-flight responses are dropped.
  - While `rst_i=1`: `gnt_o=0`, `bank_req_o=0`, `rvalid_o=0`.
  - Reset asserted mid-operation takes effect on the next edge.
  - `rdata_o` is unqualified and has no reset requirement.

## Timing
- Grant latency: 0 cycles, combinational from `req_i`.
- Combinational paths: `req_i` → `gnt_o` and `req_i` → `bank_*`. No path from `bank_rdata_i` to `gnt_o`.
- Read latency: the grant in cycle T gives `rvalid_o` in cycle T+`MemLatency`.
- Throughput: 1 access per cycle aggregate.
- Simultaneous events: a grant and a response in the same cycle to the same or different requesters are both legal and independent.
- Registered state: `rr_q` (`$clog2(NumReq)` bits, 1 when `NumReq=1`) and the response pipe (`MemLatency` × (1 + index width)).

## Structure
- Shared package: an `arb_idx_t` width helper, and `tcdm_addr_t`/`data_t`/`be_t` taken from the common mempool package.
  - The block is instantiated with `AddrMemWidth=TCDMAddrMemWidth`.
- One sub-module: `rr_pick`, a combinational round-robin priority selector with inputs `req`/`ptr` and outputs `onehot`/`idx`/`valid`. It is reusable in the tile crossbar.
- Everything else is inline: the payload mux, the pointer register, and the response shift register.

## Test plan
- Reset then idle, with `NumReq=2`:
  - during `rst_i`, `req_i=2'b11` → `gnt_o=0`, `bank_req_o=0`;
  - after release, first cycle → `gnt_o=2'b01`.
- Both ports request reads continuously, `MemLatency=1`:
  - `gnt_o` alternates 01, 10, 01, …;
  - `rvalid_o` follows the same pattern delayed 1 cycle;
  - `rdata_o` matches the model memory at the granted address.
- Write then read, with port 1 only:
  - write addr 0x5, data 0xDEADBEEF, be 4'b0101 → no `rvalid_o`;
  - next read of 0x5 → `rvalid_o=2'b10`, data 0x00AD00EF over the zero-initialised word.
- `NumReq=4`, `MemLatency=3`, random mixed requests for 10k cycles:
  - every read gets exactly one `rvalid` at the correct port, exactly 3 cycles after its grant;
  - no port waits more than 3 cycles while holding `req`.
- Reset mid-flight, `MemLatency=2`:
  - read granted at T, `rst_i` pulsed at T+1 → no `rvalid_o` at T+2;
  - `rr_q` is back to 0.
- `NumReq=1`: `req_i=1` for 5 cycles → 5 grants, 5 responses, pointer stays 0.

Source files
------------

// File: rtl/tcdm_bank_arbiter_pkg.sv
// Shared types and width helpers for the TCDM bank arbiter and its round-robin picker.
package tcdm_bank_arbiter_pkg;

    localparam int unsigned TCDMAddrMemWidth = 10;
    localparam int unsigned TCDMDataWidth    = 32;
    localparam int unsigned TCDMBeWidth      = TCDMDataWidth / 8;

    typedef logic [TCDMAddrMemWidth-1:0] tcdm_addr_t;
    typedef logic [TCDMDataWidth-1:0]    data_t;
    typedef logic [TCDMBeWidth-1:0]      be_t;

    // A single requester still carries a 1-bit index so port widths never collapse to zero.
    function automatic int unsigned arb_idx_width(input int unsigned num_req);
        return (num_req > 1) ? $clog2(num_req) : 1;
    endfunction

endpackage

// File: rtl/tcdm_bank_arbiter_rr_pick.sv
// Combinational round-robin priority selector: first asserted request at or after ptr wins.
module rr_pick
    import tcdm_bank_arbiter_pkg::*;
#(
    parameter int unsigned NumReq   = 2,
    parameter int unsigned IdxWidth = arb_idx_width(NumReq)
) (
    input  logic [NumReq-1:0]   req,
    input  logic [IdxWidth-1:0] ptr,
    output logic [NumReq-1:0]   onehot,
    output logic [IdxWidth-1:0] idx,
    output logic                valid
);

    localparam int unsigned SumWidth = IdxWidth + 1;

    logic [2*NumReq-1:0] req_dbl;
    logic [NumReq-1:0]   req_rot;
    logic [SumWidth-1:0] sum;

    // Rotate so the pointer position lands at bit 0, then take the lowest set bit.
    always_comb begin
        req_dbl = {req, req};
        req_rot = NumReq'(req_dbl >> ptr);
        valid   = 1'b0;
        sum     = '0;
        for (int k = int'(NumReq) - 1; k >= 0; k--) begin
            if (req_rot[k]) begin
                valid = 1'b1;
                sum   = {1'b0, ptr} + SumWidth'(k);
            end
        end
        if (sum >= SumWidth'(NumReq)) begin
            sum = sum - SumWidth'(NumReq);
        end
        idx    = sum[IdxWidth-1:0];
        onehot = '0;
        for (int i = 0; i < int'(NumReq); i++) begin
            onehot[i] = valid && (idx == IdxWidth'(i));
        end
    end

endmodule

// File: rtl/tcdm_bank_arbiter.sv
// Shares one TCDM SRAM bank between NumReq requesters with round-robin arbitration
// and returns each read response to its issuer after the fixed bank latency.
module tcdm_bank_arbiter
    import tcdm_bank_arbiter_pkg::*;
#(
    parameter int unsigned NumReq       = 2,
    parameter int unsigned AddrMemWidth = TCDMAddrMemWidth,
    parameter int unsigned DataWidth    = TCDMDataWidth,
    parameter int unsigned MemLatency   = 1
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [NumReq-1:0]              req_i,
    input  logic [NumReq*AddrMemWidth-1:0] addr_i,
    input  logic [NumReq-1:0]              wen_i,
    input  logic [NumReq*DataWidth-1:0]    wdata_i,
    input  logic [NumReq*DataWidth/8-1:0]  be_i,
    output logic [NumReq-1:0]              gnt_o,
    output logic [NumReq-1:0]              rvalid_o,
    output logic [DataWidth-1:0]           rdata_o,
    output logic                           bank_req_o,
    output logic [AddrMemWidth-1:0]        bank_addr_o,
    output logic                           bank_wen_o,
    output logic [DataWidth-1:0]           bank_wdata_o,
    output logic [DataWidth/8-1:0]         bank_be_o,
    input  logic [DataWidth-1:0]           bank_rdata_i
);

    localparam int unsigned IdxWidth = arb_idx_width(NumReq);
    localparam int unsigned BeWidth  = DataWidth / 8;

    logic [NumReq-1:0]                   req_live;
    logic [NumReq-1:0]                   win_onehot;
    logic [IdxWidth-1:0]                 win_idx;
    logic                                win_valid;
    logic [IdxWidth-1:0]                 rr_q;
    logic [MemLatency-1:0]               pipe_valid_q;
    logic [MemLatency-1:0][IdxWidth-1:0] pipe_idx_q;

    // Holding reset masks every request, so nothing reaches the bank or moves the pointer.
    assign req_live = rst_i ? '0 : req_i;

    rr_pick #(
        .NumReq   (NumReq),
        .IdxWidth (IdxWidth)
    ) u_rr_pick (
        .req    (req_live),
        .ptr    (rr_q),
        .onehot (win_onehot),
        .idx    (win_idx),
        .valid  (win_valid)
    );

    assign gnt_o      = win_onehot;
    assign bank_req_o = win_valid;

    always_comb begin
        bank_addr_o  = '0;
        bank_wen_o   = 1'b0;
        bank_wdata_o = '0;
        bank_be_o    = '0;
        for (int i = 0; i < int'(NumReq); i++) begin
            if (win_onehot[i]) begin
                bank_addr_o  = addr_i[i*AddrMemWidth +: AddrMemWidth];
                bank_wen_o   = wen_i[i];
                bank_wdata_o = wdata_i[i*DataWidth +: DataWidth];
                bank_be_o    = be_i[i*BeWidth +: BeWidth];
            end
        end
    end

    generate
        if (NumReq == 1) begin : g_single
            assign rr_q = '0;
        end else begin : g_multi
            logic [IdxWidth-1:0] rr_next;

            assign rr_next = (win_idx == IdxWidth'(NumReq - 1)) ? '0 : win_idx + IdxWidth'(1);

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    rr_q <= '0;
                end else if (win_valid) begin
                    rr_q <= rr_next;
                end
            end
        end
    endgenerate

    // One stage per cycle of bank latency; only reads occupy a valid slot.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pipe_valid_q <= '0;
            pipe_idx_q   <= '0;
        end else begin
            pipe_valid_q[0] <= win_valid && !bank_wen_o;
            pipe_idx_q[0]   <= win_idx;
            for (int s = 1; s < int'(MemLatency); s++) begin
                pipe_valid_q[s] <= pipe_valid_q[s-1];
                pipe_idx_q[s]   <= pipe_idx_q[s-1];
            end
        end
    end

    always_comb begin
        rvalid_o = '0;
        for (int i = 0; i < int'(NumReq); i++) begin
            rvalid_o[i] = !rst_i && pipe_valid_q[MemLatency-1]
                          && (pipe_idx_q[MemLatency-1] == IdxWidth'(i));
        end
    end

    assign rdata_o = bank_rdata_i;

endmodule

// File: tb/tb_tcdm_bank_arbiter.sv
// Bench for tcdm_bank_arbiter across four parameterisations: vector table, reset and
// single-port sequences, and a randomized 4-port run against a queue-based model.
module tb_tcdm_bank_arbiter;
    import tcdm_bank_arbiter_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- instance A: NumReq=2, MemLatency=1, with SRAM model
    logic [1:0]  a_req, a_wen, a_gnt, a_rvalid;
    logic [19:0] a_addr;
    logic [63:0] a_wdata;
    logic [7:0]  a_be;
    data_t       a_rdata, a_bank_wdata;
    data_t       a_bank_rdata = '0;
    logic        a_bank_req, a_bank_wen;
    tcdm_addr_t  a_bank_addr;
    be_t         a_bank_be;
    logic [31:0] mem_a [1024];
    logic [31:0] a_mask;

    always_comb begin
        a_mask = '0;
        for (int b = 0; b < 4; b++) a_mask[8*b +: 8] = {8{a_bank_be[b]}};
    end

    always @(posedge clk) begin
        if (a_bank_req) begin
            if (a_bank_wen) mem_a[a_bank_addr] <= (mem_a[a_bank_addr] & ~a_mask) | (a_bank_wdata & a_mask);
            else            a_bank_rdata <= mem_a[a_bank_addr];
        end
    end

    tcdm_bank_arbiter #(.NumReq(2), .AddrMemWidth(10), .DataWidth(32), .MemLatency(1)) u_a (
        .clk_i(clk), .rst_i(rst), .req_i(a_req), .addr_i(a_addr), .wen_i(a_wen),
        .wdata_i(a_wdata), .be_i(a_be), .gnt_o(a_gnt), .rvalid_o(a_rvalid), .rdata_o(a_rdata),
        .bank_req_o(a_bank_req), .bank_addr_o(a_bank_addr), .bank_wen_o(a_bank_wen),
        .bank_wdata_o(a_bank_wdata), .bank_be_o(a_bank_be), .bank_rdata_i(a_bank_rdata));

    // ---------------- instance B: NumReq=2, MemLatency=2
    logic [1:0]  b_req, b_wen, b_gnt, b_rvalid;
    logic [19:0] b_addr;
    logic [63:0] b_wdata;
    logic [7:0]  b_be;
    logic [31:0] b_rdata, b_bank_wdata;
    logic [31:0] b_bank_rdata = 32'hB0B0_0000;
    logic        b_bank_req, b_bank_wen;
    logic [9:0]  b_bank_addr;
    logic [3:0]  b_bank_be;

    tcdm_bank_arbiter #(.NumReq(2), .AddrMemWidth(10), .DataWidth(32), .MemLatency(2)) u_b (
        .clk_i(clk), .rst_i(rst), .req_i(b_req), .addr_i(b_addr), .wen_i(b_wen),
        .wdata_i(b_wdata), .be_i(b_be), .gnt_o(b_gnt), .rvalid_o(b_rvalid), .rdata_o(b_rdata),
        .bank_req_o(b_bank_req), .bank_addr_o(b_bank_addr), .bank_wen_o(b_bank_wen),
        .bank_wdata_o(b_bank_wdata), .bank_be_o(b_bank_be), .bank_rdata_i(b_bank_rdata));

    // ---------------- instance C: NumReq=4, MemLatency=3
    logic [3:0]   c_req, c_wen, c_gnt, c_rvalid;
    logic [39:0]  c_addr;
    logic [127:0] c_wdata;
    logic [15:0]  c_be;
    logic [31:0]  c_rdata, c_bank_wdata;
    logic [31:0]  c_bank_rdata = 32'hC0C0_0000;
    logic         c_bank_req, c_bank_wen;
    logic [9:0]   c_bank_addr;
    logic [3:0]   c_bank_be;

    tcdm_bank_arbiter #(.NumReq(4), .AddrMemWidth(10), .DataWidth(32), .MemLatency(3)) u_c (
        .clk_i(clk), .rst_i(rst), .req_i(c_req), .addr_i(c_addr), .wen_i(c_wen),
        .wdata_i(c_wdata), .be_i(c_be), .gnt_o(c_gnt), .rvalid_o(c_rvalid), .rdata_o(c_rdata),
        .bank_req_o(c_bank_req), .bank_addr_o(c_bank_addr), .bank_wen_o(c_bank_wen),
        .bank_wdata_o(c_bank_wdata), .bank_be_o(c_bank_be), .bank_rdata_i(c_bank_rdata));

    // ---------------- instance D: NumReq=1, MemLatency=1
    logic        d_req, d_wen, d_gnt, d_rvalid;
    logic [9:0]  d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_be;
    logic [31:0] d_rdata, d_bank_wdata;
    logic [31:0] d_bank_rdata = 32'hD00D_0000;
    logic        d_bank_req, d_bank_wen;
    logic [9:0]  d_bank_addr;
    logic [3:0]  d_bank_be;

    tcdm_bank_arbiter #(.NumReq(1), .AddrMemWidth(10), .DataWidth(32), .MemLatency(1)) u_d (
        .clk_i(clk), .rst_i(rst), .req_i(d_req), .addr_i(d_addr), .wen_i(d_wen),
        .wdata_i(d_wdata), .be_i(d_be), .gnt_o(d_gnt), .rvalid_o(d_rvalid), .rdata_o(d_rdata),
        .bank_req_o(d_bank_req), .bank_addr_o(d_bank_addr), .bank_wen_o(d_bank_wen),
        .bank_wdata_o(d_bank_wdata), .bank_be_o(d_bank_be), .bank_rdata_i(d_bank_rdata));

    // Vector table for instance A; port 0 always presents a read of address 3.
    typedef struct {
        logic        rst;
        logic [1:0]  req;
        logic [1:0]  wen;
        logic [9:0]  addr1;
        logic [31:0] wdata1;
        logic [3:0]  be1;
        logic [1:0]  gnt;
        logic [1:0]  rvalid;
        logic        breq;
        logic        bwen;
        logic [9:0]  baddr;
        logic        chk_rdata;
        logic [31:0] rdata;
    } vec_t;

    vec_t vecs [10];

    typedef struct {
        int due;
        int port;
    } resp_t;

    resp_t exp_q[$];

    initial begin
        for (int i = 0; i < 1024; i++) mem_a[i] <= (i == 5) ? 32'h0 : 32'h1000_0000 + 32'(i * 3);
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int cnt_g, cnt_r;
        int wait_c [4];
        logic [3:0] exp_gnt, exp_rv, gnt_seen;
        int ptr_m;

        vecs[0] = '{1'b1, 2'b11, 2'b00, 10'd7, 32'h0,         4'hF, 2'b00, 2'b00, 1'b0, 1'b0, 10'd0, 1'b0, 32'h0};
        vecs[1] = '{1'b0, 2'b11, 2'b00, 10'd7, 32'h0,         4'hF, 2'b01, 2'b00, 1'b1, 1'b0, 10'd3, 1'b0, 32'h0};
        vecs[2] = '{1'b0, 2'b11, 2'b00, 10'd7, 32'h0,         4'hF, 2'b10, 2'b01, 1'b1, 1'b0, 10'd7, 1'b1, 32'h1000_0009};
        vecs[3] = '{1'b0, 2'b11, 2'b00, 10'd7, 32'h0,         4'hF, 2'b01, 2'b10, 1'b1, 1'b0, 10'd3, 1'b1, 32'h1000_0015};
        vecs[4] = '{1'b0, 2'b11, 2'b00, 10'd7, 32'h0,         4'hF, 2'b10, 2'b01, 1'b1, 1'b0, 10'd7, 1'b1, 32'h1000_0009};
        vecs[5] = '{1'b0, 2'b00, 2'b00, 10'd7, 32'h0,         4'hF, 2'b00, 2'b10, 1'b0, 1'b0, 10'd0, 1'b1, 32'h1000_0015};
        vecs[6] = '{1'b0, 2'b10, 2'b10, 10'd5, 32'hDEADBEEF,  4'h5, 2'b10, 2'b00, 1'b1, 1'b1, 10'd5, 1'b0, 32'h0};
        vecs[7] = '{1'b0, 2'b10, 2'b00, 10'd5, 32'h0,         4'hF, 2'b10, 2'b00, 1'b1, 1'b0, 10'd5, 1'b0, 32'h0};
        vecs[8] = '{1'b0, 2'b00, 2'b00, 10'd5, 32'h0,         4'hF, 2'b00, 2'b10, 1'b0, 1'b0, 10'd0, 1'b1, 32'h00AD_00EF};
        vecs[9] = '{1'b0, 2'b01, 2'b00, 10'd5, 32'h0,         4'hF, 2'b01, 2'b00, 1'b1, 1'b0, 10'd3, 1'b0, 32'h0};

        rst = 1'b1;
        a_req = '0; a_wen = '0; a_addr = '0; a_wdata = '0; a_be = '0;
        b_req = '0; b_wen = '0; b_addr = '0; b_wdata = '0; b_be = '0;
        c_req = '0; c_wen = '0; c_addr = '0; c_wdata = '0; c_be = '0;
        d_req = '0; d_wen = '0; d_addr = '0; d_wdata = '0; d_be = '0;
        repeat (2) @(posedge clk);

        // ---- A: reset, alternating reads, write-then-read
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            rst     = vecs[i].rst;
            a_req   = vecs[i].req;
            a_wen   = vecs[i].wen;
            a_addr  = {vecs[i].addr1, 10'd3};
            a_wdata = {vecs[i].wdata1, 32'h0};
            a_be    = {vecs[i].be1, 4'hF};
            @(negedge clk);
            check($sformatf("a_gnt[%0d]", i),       a_gnt,       vecs[i].gnt);
            check($sformatf("a_rvalid[%0d]", i),    a_rvalid,    vecs[i].rvalid);
            check($sformatf("a_bank_req[%0d]", i),  a_bank_req,  vecs[i].breq);
            check($sformatf("a_bank_addr[%0d]", i), a_bank_addr, vecs[i].baddr);
            check($sformatf("a_bank_wen[%0d]", i),  a_bank_wen,  vecs[i].bwen);
            if (vecs[i].bwen) begin
                check($sformatf("a_bank_wdata[%0d]", i), a_bank_wdata, vecs[i].wdata1);
                check($sformatf("a_bank_be[%0d]", i),    a_bank_be,    vecs[i].be1);
            end
            if (vecs[i].chk_rdata)
                check($sformatf("a_rdata[%0d]", i), a_rdata, vecs[i].rdata);
        end
        @(posedge clk); #1;
        a_req = '0;

        // ---- B: reset pulse while a read is in flight
        b_req = 2'b01; b_wen = 2'b00; b_addr = {10'd2, 10'd1};
        b_wdata = {32'h0, 32'hCAFE_0001}; b_be = 8'h03;
        @(negedge clk);
        check("b_gnt_T", b_gnt, 2'b01);
        check("b_bank_req_T", b_bank_req, 1'b1);
        check("b_bank_addr_T", b_bank_addr, 10'd1);
        check("b_bank_wen_T", b_bank_wen, 1'b0);
        check("b_bank_wdata_T", b_bank_wdata, 32'hCAFE_0001);
        check("b_bank_be_T", b_bank_be, 4'h3);
        @(posedge clk); #1;
        rst = 1'b1; b_req = 2'b00;
        @(negedge clk);
        check("b_rvalid_in_rst", b_rvalid, 2'b00);
        check("b_gnt_in_rst", b_gnt, 2'b00);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("b_rvalid_flushed", b_rvalid, 2'b00);
        @(posedge clk); #1;
        b_req = 2'b11;
        @(negedge clk);
        check("b_ptr_reset", b_gnt, 2'b01);
        @(posedge clk); #1;
        b_req = 2'b00;
        @(negedge clk);
        check("b_rvalid_early", b_rvalid, 2'b00);
        @(posedge clk); #1;
        @(negedge clk);
        check("b_rvalid_lat2", b_rvalid, 2'b01);
        check("b_rdata_pass", b_rdata, 32'hB0B0_0000);

        // ---- C: randomized 4-port run against a queue-based model
        ptr_m = 0;
        gnt_seen = '0;
        for (int i = 0; i < 4; i++) wait_c[i] = 0;
        for (int cyc = 0; cyc < 10010; cyc++) begin
            @(posedge clk); #1;
            c_req = c_req & ~gnt_seen;
            for (int i = 0; i < 4; i++) begin
                if (!c_req[i] && cyc < 10000 && $urandom_range(0, 9) < 6) begin
                    c_req[i]              = 1'b1;
                    c_wen[i]              = ($urandom_range(0, 2) == 0);
                    c_addr[i*10 +: 10]    = 10'($urandom);
                    c_wdata[i*32 +: 32]   = $urandom;
                    c_be[i*4 +: 4]        = 4'($urandom);
                    wait_c[i]             = 0;
                end
            end
            @(negedge clk);
            w = -1;
            for (int k = 0; k < 4; k++)
                if (w < 0 && c_req[(ptr_m + k) % 4]) w = (ptr_m + k) % 4;
            exp_gnt = (w >= 0) ? 4'(1 << w) : 4'b0;
            check("c_gnt", c_gnt, exp_gnt);
            check("c_bank_req", c_bank_req, (w >= 0));
            if (w >= 0) begin
                check("c_bank_addr",  c_bank_addr,  c_addr[w*10 +: 10]);
                check("c_bank_wen",   c_bank_wen,   c_wen[w]);
                check("c_bank_wdata", c_bank_wdata, c_wdata[w*32 +: 32]);
                check("c_bank_be",    c_bank_be,    c_be[w*4 +: 4]);
                if (!c_wen[w]) exp_q.push_back('{cyc + 3, w});
                ptr_m = (w + 1) % 4;
            end
            exp_rv = '0;
            while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
                if (exp_q[0].due == cyc) exp_rv = exp_rv | 4'(1 << exp_q[0].port);
                void'(exp_q.pop_front());
            end
            check("c_rvalid", c_rvalid, exp_rv);
            for (int i = 0; i < 4; i++) begin
                if (c_req[i]) begin
                    if (c_gnt[i]) check("c_fair_wait", (wait_c[i] <= 3), 1'b1);
                    else          wait_c[i]++;
                end
            end
            gnt_seen = c_gnt;
        end
        check("c_queue_empty", exp_q.size(), 0);
        check("c_rdata_pass", c_rdata, 32'hC0C0_0000);

        // ---- D: single requester
        cnt_g = 0; cnt_r = 0;
        d_addr = 10'h2A; d_wen = 1'b0; d_wdata = 32'h1234_5678; d_be = 4'hC;
        for (int c = 0; c < 7; c++) begin
            @(posedge clk); #1;
            d_req = (c < 5);
            @(negedge clk);
            check($sformatf("d_gnt[%0d]", c), d_gnt, (c < 5));
            check($sformatf("d_bank_req[%0d]", c), d_bank_req, (c < 5));
            check($sformatf("d_rvalid[%0d]", c), d_rvalid, (c >= 1 && c <= 5));
            if (c == 0) begin
                check("d_bank_addr", d_bank_addr, 10'h2A);
                check("d_bank_wen", d_bank_wen, 1'b0);
                check("d_bank_wdata", d_bank_wdata, 32'h1234_5678);
                check("d_bank_be", d_bank_be, 4'hC);
                check("d_rdata_pass", d_rdata, 32'hD00D_0000);
            end
            if (d_gnt === 1'b1) cnt_g++;
            if (d_rvalid === 1'b1) cnt_r++;
        end
        check("d_grant_count", cnt_g, 5);
        check("d_resp_count", cnt_r, 5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
